// File: rtl/rf_arb_pkg.sv
// Shared widths, the id-width helper and the registered response record for rf_port_arbiter.
// Data width defaults to the 16x32 register_file geometry.
package rf_arb_pkg;

    localparam int RF_NUM_REGS = 16;
    localparam int RF_ADDR_W   = 4;
    localparam int RF_DATA_W   = 32;
    localparam int MAX_REQ     = 8;
    localparam int MAX_ID_W    = $clog2(MAX_REQ);

    // Width of a requester index; a single requester still needs one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic                 valid;
        logic [MAX_ID_W-1:0]  id;
        logic [RF_DATA_W-1:0] data0;
        logic [RF_DATA_W-1:0] data1;
    } rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from a rotating pointer.
// Latency: grant is combinational from req and pointer; pointer moves past the winner at the clock edge.
// Backpressure: none; a requester simply holds req until it sees its grant.
module rr_arbiter
    import rf_arb_pkg::*;
#(
    parameter int N  = 3,
    parameter int PW = id_w(N)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic          gnt_vld,
    output logic [PW-1:0] gnt_idx
);

    logic [PW-1:0] ptr;

    // Two passes: indices at or above the pointer first, then the wrapped ones below it.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (reset_n) begin
            for (int i = 0; i < N; i++) begin
                if (!gnt_vld && req[i] && (i >= int'(ptr))) begin
                    gnt_vld = 1'b1;
                    gnt_idx = PW'(i);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!gnt_vld && req[i] && (i < int'(ptr))) begin
                    gnt_vld = 1'b1;
                    gnt_idx = PW'(i);
                end
            end
            if (gnt_vld) begin
                gnt[gnt_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (gnt_vld) begin
            ptr <= (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
        end
    end

endmodule

// File: rtl/rf_port_arbiter.sv
// Shares the two read ports and one write port of register_file between NUM_REQ requesters.
// Latency: grants and rf_* drive are combinational; the tagged read response follows one cycle after the grant.
// Backpressure: requesters hold until granted; responses cannot be stalled.
module rf_port_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int NUM_REGS = rf_arb_pkg::RF_NUM_REGS,
    parameter int ADDR_W   = rf_arb_pkg::RF_ADDR_W,
    parameter int DATA_W   = rf_arb_pkg::RF_DATA_W
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        rd_req,
    input  logic [2*NUM_REQ-1:0]      rd_mask,
    input  logic [ADDR_W*NUM_REQ-1:0] rd_addr0,
    input  logic [ADDR_W*NUM_REQ-1:0] rd_addr1,
    output logic [NUM_REQ-1:0]        rd_gnt,
    input  logic [NUM_REQ-1:0]        wr_req,
    input  logic [ADDR_W*NUM_REQ-1:0] wr_addr,
    input  logic [DATA_W*NUM_REQ-1:0] wr_data,
    output logic [NUM_REQ-1:0]        wr_gnt,
    output logic                      rsp_valid,
    output logic [id_w(NUM_REQ)-1:0]  rsp_id,
    output logic [DATA_W-1:0]         rsp_data0,
    output logic [DATA_W-1:0]         rsp_data1,
    output logic [1:0]                rf_read_en,
    output logic [ADDR_W-1:0]         rf_raddr_0,
    output logic [ADDR_W-1:0]         rf_raddr_1,
    output logic                      rf_write_en,
    output logic [ADDR_W-1:0]         rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata,
    input  logic [DATA_W-1:0]         rf_rdata_0,
    input  logic [DATA_W-1:0]         rf_rdata_1
);

    localparam int ID_W = id_w(NUM_REQ);

    if (ADDR_W != $clog2(NUM_REGS)) begin : g_addr_w_chk
        $error("rf_port_arbiter: ADDR_W must equal clog2(NUM_REGS)");
    end
    if ((NUM_REQ < 2) || (NUM_REQ > MAX_REQ)) begin : g_num_req_chk
        $error("rf_port_arbiter: NUM_REQ must be 2..8");
    end

    logic            rd_win_vld;
    logic            wr_win_vld;
    logic [ID_W-1:0] rd_win_idx;
    logic [ID_W-1:0] wr_win_idx;

    rr_arbiter #(.N(NUM_REQ), .PW(ID_W)) u_rd_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (rd_req),
        .gnt     (rd_gnt),
        .gnt_vld (rd_win_vld),
        .gnt_idx (rd_win_idx)
    );

    rr_arbiter #(.N(NUM_REQ), .PW(ID_W)) u_wr_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (wr_req),
        .gnt     (wr_gnt),
        .gnt_vld (wr_win_vld),
        .gnt_idx (wr_win_idx)
    );

    logic [1:0]        mask_a  [NUM_REQ];
    logic [ADDR_W-1:0] raddr0_a[NUM_REQ];
    logic [ADDR_W-1:0] raddr1_a[NUM_REQ];
    logic [ADDR_W-1:0] waddr_a [NUM_REQ];
    logic [DATA_W-1:0] wdata_a [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            mask_a[i]   = rd_mask[2*i +: 2];
            raddr0_a[i] = rd_addr0[ADDR_W*i +: ADDR_W];
            raddr1_a[i] = rd_addr1[ADDR_W*i +: ADDR_W];
            waddr_a[i]  = wr_addr[ADDR_W*i +: ADDR_W];
            wdata_a[i]  = wr_data[DATA_W*i +: DATA_W];
        end
    end

    // Register-file pins stay at zero unless the matching port has a winner.
    always_comb begin
        rf_read_en  = 2'b00;
        rf_raddr_0  = '0;
        rf_raddr_1  = '0;
        rf_write_en = 1'b0;
        rf_waddr    = '0;
        rf_wdata    = '0;
        if (rd_win_vld) begin
            rf_read_en = mask_a[rd_win_idx];
            rf_raddr_0 = raddr0_a[rd_win_idx];
            rf_raddr_1 = raddr1_a[rd_win_idx];
        end
        if (wr_win_vld) begin
            rf_write_en = 1'b1;
            rf_waddr    = waddr_a[wr_win_idx];
            rf_wdata    = wdata_a[wr_win_idx];
        end
    end

    // register_file returns the pre-write value on a same-cycle collision, so the new data is kept here.
    logic [1:0] byp_hit;

    always_comb begin
        byp_hit    = 2'b00;
        byp_hit[0] = rf_write_en && rf_read_en[0] && (rf_waddr == rf_raddr_0);
        byp_hit[1] = rf_write_en && rf_read_en[1] && (rf_waddr == rf_raddr_1);
    end

    rsp_t       rsp_q;
    logic [1:0] byp_q;
    logic [1:0] en_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rsp_q <= '0;
            byp_q <= 2'b00;
            en_q  <= 2'b00;
        end else begin
            rsp_q.valid <= rd_win_vld;
            rsp_q.id    <= MAX_ID_W'(rd_win_idx);
            rsp_q.data0 <= byp_hit[0] ? rf_wdata : '0;
            rsp_q.data1 <= byp_hit[1] ? rf_wdata : '0;
            byp_q       <= byp_hit;
            en_q        <= rf_read_en;
        end
    end

    logic id_unused;
    assign id_unused = ^rsp_q.id;

    assign rsp_valid = rsp_q.valid;
    assign rsp_id    = rsp_q.id[ID_W-1:0];
    assign rsp_data0 = byp_q[0] ? rsp_q.data0 : (en_q[0] ? rf_rdata_0 : '0);
    assign rsp_data1 = byp_q[1] ? rsp_q.data1 : (en_q[1] ? rf_rdata_1 : '0);

endmodule

// File: doc/rf_port_arbiter.md
Name: rf_port_arbiter

Overview:
- Shares the 16x32 two-read/one-write register_file between NUM_REQ requesters, such as lanes or issue slots.
- Runs independent round-robin arbitration for the read-port pair and for the write port.
- Drives the register_file control and address pins, returns read data tagged with the requester id, and forwards same-cycle write data to a conflicting read.
- Sits between the issue/writeback logic and register_file.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
NUM_REGS, 16, registers in register_file
ADDR_W, 4, register address width, equal to clog2(NUM_REGS)
DATA_W, 32, register data width

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
rd_req  in  NUM_REQ  per-requester read request
rd_mask  in  2*NUM_REQ  per-requester operand enables; bit0 selects operand 0, bit1 selects operand 1
rd_addr0  in  ADDR_W*NUM_REQ  per-requester operand-0 address
rd_addr1  in  ADDR_W*NUM_REQ  per-requester operand-1 address
rd_gnt  out  NUM_REQ  one-hot read grant
wr_req  in  NUM_REQ  per-requester write request
wr_addr  in  ADDR_W*NUM_REQ  per-requester write address
wr_data  in  DATA_W*NUM_REQ  per-requester write data
wr_gnt  out  NUM_REQ  one-hot write grant
rsp_valid  out  1  read response valid
rsp_id  out  clog2(NUM_REQ)  index of the requester that owns the response
rsp_data0  out  DATA_W  operand-0 data
rsp_data1  out  DATA_W  operand-1 data
rf_read_en  out  2  to register_file read_en
rf_raddr_0  out  ADDR_W  to register_file raddr_0
rf_raddr_1  out  ADDR_W  to register_file raddr_1
rf_write_en  out  1  to register_file write_en
rf_waddr  out  ADDR_W  to register_file waddr
rf_wdata  out  DATA_W  to register_file wdata
rf_rdata_0  in  DATA_W  from register_file rdata_0
rf_rdata_1  in  DATA_W  from register_file rdata_1

Behaviour:
- Handshake:
  - A requester holds req, addr, mask and data stable until it sees its gnt.
  - The transfer happens in the cycle where req and gnt are both high.
  - gnt is combinational from req and the round-robin pointer.
- Read arbitration:
  - At most one requester is granted per cycle, and it uses both read ports.
  - The search starts at rd_ptr and moves upward, wrapping at NUM_REQ.
  - After a grant to index i, rd_ptr <= (i+1) mod NUM_REQ. With no grant, rd_ptr holds.
- Write arbitration: identical scheme with its own wr_ptr, independent of the read arbitration.
- register_file drive in a grant cycle:
  - Read grant: rf_read_en = rd_mask of the winner, rf_raddr_0/1 = the winner's rd_addr0/rd_addr1.
  - Write grant: rf_write_en=1, rf_waddr and rf_wdata from the winner.
  - No grant: all rf_* outputs are 0.
- register_file timing:
  - Reads are registered: rdata is valid the cycle after read_en.
  - A write takes effect at the end of the grant cycle.
  - Same-cycle write to a register being read returns the old value from register_file.
- Response:
  - Registered. rsp_valid=1 exactly one cycle after a read grant. rsp_id is the winner captured in the grant cycle.
  - rsp_dataK = rf_rdata_K if mask bit K was set, otherwise 0.
  - rsp_valid=0 in every cycle not preceded by a read grant.
  - Back-to-back grants give a response every cycle. There is no backpressure on responses.
- Bypass:
  - If the write grant and read grant fall in the same cycle and rf_waddr equals rf_raddr_K with mask bit K set, rsp_dataK = that cycle's wr_data.
  - The arbiter keeps a registered hit flag and data per port to do this.
- rd_mask=2'b00 with rd_req=1:
  - Still granted, with rf_read_en=0.
  - The response is valid with both data fields 0.
- There is no hardwired-zero register. Register 0 is ordinary.
- Reset (reset_n low at a clk edge):
  - rd_ptr and wr_ptr go to 0.
  - rsp_valid, rsp_id, rsp_data0/1 and the bypass flags go to 0.
  - While reset_n is low, rd_gnt, wr_gnt and all rf_* enables are forced to 0.
  - A grant issued in the cycle when reset asserts produces no response.
- Simultaneous read and write by the same requester are legal, and each is arbitrated independently.
- Inactive requesters are skipped with no penalty cycle.

Decomposition:
- Package rf_arb_pkg holds ADDR_W, DATA_W and the NUM_REGS defaults, the id width function, and the rsp_t struct (valid, id, data0, data1).
- Sub-module rr_arbiter (parameter N; ports req, gnt, pointer update) is instantiated twice, once for read and once for write.

Test Plan:
- Reset default: reset_n low 10 cycles, then requester 0 reads addresses 0..15 back-to-back with mask 2'b11 -> 16 consecutive responses, rsp_id=0, all data 32'h0, no gaps.
- Write contention: requesters 0, 1 and 2 raise wr_req together to addresses 1, 2 and 3 with data 32'hA, 32'hB and 32'hC -> wr_gnt goes 001, 010, 100 over 3 cycles. Subsequent reads of those addresses return 32'hA, 32'hB and 32'hC.
- Read fairness: all three rd_req held high for 6 cycles -> rd_gnt sequence 0,1,2,0,1,2. rsp_id shows 0,1,2,0,1,2, each one cycle behind its grant.
- Bypass: register 5 holds 0. In one cycle requester 0 writes 5=32'hDEADBEEF while requester 1 reads addr0=5 with mask 2'b01 -> next cycle rsp_id=1, rsp_data0=32'hDEADBEEF, rsp_data1=0.
- Mask and reset mid-operation: mask 2'b10 gives rf_read_en=2'b10 and rsp_data0=0.
- Reset mid-operation:
  - Read grant in cycle N, then reset_n low at the end of cycle N -> rsp_valid stays 0.
  - After release, with all requesters active, the first grant goes to requester 0.
